// File: rtl/cfg_reg_pkg.sv
// Register map, response codes and shared types for the P2P filter config block.
//
// Word index = byte address [6:2]:
//   0x00-0x05  rule 0 : ipv4_addr, ipv6_addr w0..w3 (w0 = bits [31:0]), {flags, proto, port}
//   0x06-0x0B  rule 1 : same layout as rule 0
//   0x0C-0x0F  counters: rule0_hit, rule1_hit, pkt_seen, pkt_drop
//   0x10       CTRL    : bit0 COMMIT, bit1 CLR_ALL (self-clearing, read as 0)
//   >= 0x11    unmapped
package cfg_reg_pkg;

  localparam int NUM_RULES        = 2;
  localparam int RULE_WORDS       = 6;
  localparam int NUM_SHADOW_WORDS = NUM_RULES * RULE_WORDS;
  localparam int NUM_COUNTERS     = 4;

  localparam logic [4:0] CNT_BASE_OFFSET  = 5'h0C;
  localparam logic [4:0] CTRL_OFFSET      = 5'h10;
  localparam int         CTRL_COMMIT_BIT  = 0;
  localparam int         CTRL_CLR_ALL_BIT = 1;
  localparam int         NUM_REG_WORDS    = 17;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order makes the packed rule identical to its six register words
  // concatenated {w5, w4, w3, w2, w1, w0}.
  typedef struct packed {
    logic [7:0]   flags;
    logic [7:0]   proto;
    logic [15:0]  port;
    logic [127:0] ipv6_addr;
    logic [31:0]  ipv4_addr;
  } rule_t;

  typedef rule_t [NUM_RULES-1:0] rule_array_t;

  typedef struct packed {
    logic [31:0] pkt_drop;
    logic [31:0] pkt_seen;
    logic [31:0] rule1_hit;
    logic [31:0] rule0_hit;
  } counters_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Byte-lane merge of a register write.
  function automatic logic [31:0] applyStrb(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic rule_array_t wordsToRules(input logic [NUM_SHADOW_WORDS-1:0][31:0] w);
    return rule_array_t'(w);
  endfunction

endpackage

// File: rtl/p2p_event_counter.sv
// 32-bit wrapping event counter.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   inc_i          : add one this cycle
//   clr_i          : clear this cycle; a coincident inc_i still counts (result 1)
//   count_o        : current count
module p2p_event_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        clr_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  // Clear wins over the old value but never swallows the increment of the same cycle.
  always_comb begin
    count_d = count_q + 32'(inc_i);
    if (clr_i) begin
      count_d = 32'(inc_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/p2p_cfg_axil_ctrl.sv
// AXI4-Lite slave owning the P2P filter configuration: shadow rule registers,
// atomic commit to the active rule set, and the four packet counters.
//   axis_aclk / axis_aresetn : clock, asynchronous active-low reset
//   s_axil_aw* / w* / b*     : write channel (one outstanding write)
//   s_axil_ar* / r*          : read channel (independent of writes)
//   rule0_hit, rule1_hit, pkt_seen, pkt_drop : event pulses from the filter
//   active_rules             : committed rules to the datapath
//   counters                 : live counter values
module p2p_cfg_axil_ctrl
  import cfg_reg_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  input  logic              rule0_hit,
  input  logic              rule1_hit,
  input  logic              pkt_seen,
  input  logic              pkt_drop,
  output rule_array_t       active_rules,
  output counters_t         counters
);

  logic                  rdyEn_q;
  wr_state_e             wrState_q, wrState_d;
  logic                  awHeld_q, awHeld_d;
  logic [ADDR_W-3:0]     awAddr_q, awAddr_d;
  logic                  wHeld_q, wHeld_d;
  logic [31:0]           wData_q, wData_d;
  logic [3:0]            wStrb_q, wStrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  rd_state_e             rdState_q, rdState_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [NUM_SHADOW_WORDS-1:0][31:0] shadow_q;
  rule_array_t                       active_q;
  logic [NUM_COUNTERS-1:0][31:0]     cntVal;
  logic [NUM_COUNTERS-1:0]           cntInc, cntClr;

  logic              awFire, wFire, arFire, doWrite;
  logic [ADDR_W-3:0] wrWordAddr, rdWordAddr;
  logic [4:0]        wrIdx, rdIdx;
  logic              wrMapped, rdMapped;
  logic [31:0]       wrData;
  logic [3:0]        wrStrb;
  logic              ctrlWr, commit, clrAll;
  logic [31:0]       rdWord;
  logic [1:0]        rdResp;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Readies stay low through reset and come up on the first edge after release.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rdyEn_q <= 1'b0;
    end else begin
      rdyEn_q <= 1'b1;
    end
  end

  assign s_axil_awready = rdyEn_q && (wrState_q == W_IDLE) && !awHeld_q;
  assign s_axil_wready  = rdyEn_q && (wrState_q == W_IDLE) && !wHeld_q;
  assign s_axil_arready = rdyEn_q && (rdState_q == R_IDLE);

  assign awFire = s_axil_awvalid && s_axil_awready;
  assign wFire  = s_axil_wvalid  && s_axil_wready;
  assign arFire = s_axil_arvalid && s_axil_arready;

  // The write executes in the cycle the later of AW/W arrives, using the held beat
  // for whichever came first. Address bits above bit 6 mark the access unmapped
  // rather than aliasing onto the register window.
  assign wrWordAddr = awHeld_q ? awAddr_q : s_axil_awaddr[ADDR_W-1:2];
  assign wrData     = wHeld_q  ? wData_q  : s_axil_wdata;
  assign wrStrb     = wHeld_q  ? wStrb_q  : s_axil_wstrb;
  assign wrIdx      = wrWordAddr[4:0];
  assign wrMapped   = (wrWordAddr[ADDR_W-3:5] == '0) && (wrIdx < 5'(NUM_REG_WORDS));
  assign doWrite    = (wrState_q == W_IDLE) && (awHeld_q || awFire) && (wHeld_q || wFire);

  assign ctrlWr = doWrite && wrMapped && (wrIdx == CTRL_OFFSET) && wrStrb[0];
  assign commit = ctrlWr && wrData[CTRL_COMMIT_BIT];
  assign clrAll = ctrlWr && wrData[CTRL_CLR_ALL_BIT];

  always_comb begin
    wrState_d = wrState_q;
    awHeld_d  = awHeld_q;
    awAddr_d  = awAddr_q;
    wHeld_d   = wHeld_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wrState_q)
      W_IDLE: begin
        if (doWrite) begin
          awHeld_d  = 1'b0;
          wHeld_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wrMapped ? RESP_OKAY : RESP_SLVERR;
          wrState_d = W_RESP;
        end else begin
          if (awFire) begin
            awHeld_d = 1'b1;
            awAddr_d = s_axil_awaddr[ADDR_W-1:2];
          end
          if (wFire) begin
            wHeld_d = 1'b1;
            wData_d = s_axil_wdata;
            wStrb_d = s_axil_wstrb;
          end
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          wrState_d = W_IDLE;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wrState_q <= W_IDLE;
      awHeld_q  <= 1'b0;
      awAddr_q  <= '0;
      wHeld_q   <= 1'b0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wrState_q <= wrState_d;
      awHeld_q  <= awHeld_d;
      awAddr_q  <= awAddr_d;
      wHeld_q   <= wHeld_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;

  // Shadow rules take byte-masked host writes; active rules copy the whole shadow at once.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SHADOW_WORDS; i++) begin
        if (doWrite && wrMapped && (wrIdx == 5'(i))) begin
          shadow_q[i] <= applyStrb(shadow_q[i], wrData, wrStrb);
        end
      end
      if (commit) begin
        active_q <= wordsToRules(shadow_q);
      end
    end
  end

  assign active_rules = active_q;

  assign cntInc = {pkt_drop, pkt_seen, rule1_hit, rule0_hit};

  // A counter write clears that counter regardless of data or strobes.
  always_comb begin
    cntClr = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cntClr[i] = clrAll || (doWrite && wrMapped && (wrIdx == CNT_BASE_OFFSET + 5'(i)));
    end
  end

  p2p_event_counter uCntRule0Hit (
    .clk_i(axis_aclk), .rst_ni(axis_aresetn), .inc_i(cntInc[0]), .clr_i(cntClr[0]), .count_o(cntVal[0])
  );
  p2p_event_counter uCntRule1Hit (
    .clk_i(axis_aclk), .rst_ni(axis_aresetn), .inc_i(cntInc[1]), .clr_i(cntClr[1]), .count_o(cntVal[1])
  );
  p2p_event_counter uCntPktSeen (
    .clk_i(axis_aclk), .rst_ni(axis_aresetn), .inc_i(cntInc[2]), .clr_i(cntClr[2]), .count_o(cntVal[2])
  );
  p2p_event_counter uCntPktDrop (
    .clk_i(axis_aclk), .rst_ni(axis_aresetn), .inc_i(cntInc[3]), .clr_i(cntClr[3]), .count_o(cntVal[3])
  );

  assign counters = counters_t'(cntVal);

  // Read mux: shadow (not active) values, counters as of AR acceptance, CTRL reads 0.
  assign rdWordAddr = s_axil_araddr[ADDR_W-1:2];
  assign rdIdx      = rdWordAddr[4:0];
  assign rdMapped   = (rdWordAddr[ADDR_W-3:5] == '0) && (rdIdx < 5'(NUM_REG_WORDS));

  always_comb begin
    rdWord = '0;
    rdResp = RESP_SLVERR;
    if (rdMapped) begin
      rdResp = RESP_OKAY;
      for (int i = 0; i < NUM_SHADOW_WORDS; i++) begin
        if (rdIdx == 5'(i)) begin
          rdWord = shadow_q[i];
        end
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (rdIdx == CNT_BASE_OFFSET + 5'(i)) begin
          rdWord = cntVal[i];
        end
      end
    end
  end

  always_comb begin
    rdState_d = rdState_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rdState_q)
      R_IDLE: begin
        if (arFire) begin
          rvalid_d  = 1'b1;
          rdata_d   = rdWord;
          rresp_d   = rdResp;
          rdState_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rdState_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdState_q <= rdState_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;

endmodule

// File: tb/tb_p2p_cfg_axil_ctrl.sv
// Directed self-checking bench for p2p_cfg_axil_ctrl.
module tb_p2p_cfg_axil_ctrl;
  import cfg_reg_pkg::*;

  logic        clk;
  logic        rstN;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        rule0Hit, rule1Hit, pktSeen, pktDrop;
  rule_array_t activeRules;
  counters_t   cnts;

  int total = 0;
  int bad   = 0;

  logic [31:0] rdVal;
  logic [1:0]  respVal;

  p2p_cfg_axil_ctrl #(.ADDR_W(12)) dut (
    .axis_aclk(clk), .axis_aresetn(rstN),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .rule0_hit(rule0Hit), .rule1_hit(rule1Hit), .pkt_seen(pktSeen), .pkt_drop(pktDrop),
    .active_rules(activeRules), .counters(cnts)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write transaction; called and returns just after a falling edge.
  task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int   cyc;
    logic awDone, wDone, awGo, wGo, stuck;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    awDone = 1'b0; wDone = 1'b0; cyc = 0;
    while (!(awDone && wDone) && cyc < 20) begin
      awGo = awvalid && awready;
      wGo  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (awGo) begin awvalid = 1'b0; awDone = 1'b1; end
      if (wGo)  begin wvalid  = 1'b0; wDone  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    resp  = bresp;
    stuck = !bvalid || !awDone || !wDone;
    checkOutput("write completes", 32'(stuck), 32'd0);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axiRead(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   cyc;
    logic arDone, arGo, stuck;
    araddr = addr; arvalid = 1'b1; arDone = 1'b0; cyc = 0;
    while (!arDone && cyc < 20) begin
      arGo = arvalid && arready;
      @(negedge clk);
      cyc++;
      if (arGo) begin arvalid = 1'b0; arDone = 1'b1; end
    end
    arvalid = 1'b0;
    rready = 1'b1; cyc = 0;
    while (!rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    data  = rdata;
    resp  = rresp;
    stuck = !rvalid || !arDone;
    checkOutput("read completes", 32'(stuck), 32'd0);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    rule0Hit = 0; rule1Hit = 0; pktSeen = 0; pktDrop = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst awready", 32'(awready), 32'd0);
    checkOutput("rst arready", 32'(arready), 32'd0);
    checkOutput("rst bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst rdata", rdata, 32'd0);
    checkOutput("rst active nonzero", 32'(activeRules != '0), 32'd0);
    rstN = 1'b1;
    checkOutput("release awready same cycle", 32'(awready), 32'd0);
    @(negedge clk);
    checkOutput("post-release readies", {29'd0, awready, wready, arready}, 32'h7);

    // Shadow writes then commit
    axiWrite(12'h000, 32'hC0A80001, 4'hF, respVal);
    checkOutput("wr 0x000 bresp", 32'(respVal), 32'(RESP_OKAY));
    axiWrite(12'h018, 32'h0A000001, 4'hF, respVal);
    axiWrite(12'h008, 32'h20010DB8, 4'hF, respVal);
    checkOutput("active ipv4 before commit", activeRules[0].ipv4_addr, 32'd0);
    awaddr = 12'h040; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    checkOutput("active ipv4 in commit cycle", activeRules[0].ipv4_addr, 32'd0);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    checkOutput("commit bvalid next cycle", 32'(bvalid), 32'd1);
    checkOutput("active r0 ipv4 after commit", activeRules[0].ipv4_addr, 32'hC0A80001);
    checkOutput("active r1 ipv4 after commit", activeRules[1].ipv4_addr, 32'h0A000001);
    checkOutput("active r0 ipv6 w1", activeRules[0].ipv6_addr[63:32], 32'h20010DB8);
    checkOutput("active r0 ipv6 w0", activeRules[0].ipv6_addr[31:0], 32'h0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    checkOutput("bvalid dropped after bready", 32'(bvalid), 32'd0);
    axiRead(12'h000, rdVal, respVal);
    checkOutput("rd 0x000 data", rdVal, 32'hC0A80001);
    checkOutput("rd 0x000 resp", 32'(respVal), 32'(RESP_OKAY));
    axiRead(12'h040, rdVal, respVal);
    checkOutput("ctrl reads 0", rdVal, 32'd0);

    // Shadow is read back, active keeps committed value
    axiWrite(12'h000, 32'h11111111, 4'hF, respVal);
    axiRead(12'h000, rdVal, respVal);
    checkOutput("rd shadow not active", rdVal, 32'h11111111);
    checkOutput("active held w/o commit", activeRules[0].ipv4_addr, 32'hC0A80001);

    // W beat three cycles ahead of AW, partial strobes, stalled B
    wdata = 32'hFFFF1234; wstrb = 4'h3; wvalid = 1;
    checkOutput("wready idle", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 0;
    checkOutput("wready low once held", 32'(wready), 32'd0);
    checkOutput("awready still high", 32'(awready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    awaddr = 12'h014; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    checkOutput("bvalid cycle after AW", 32'(bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bvalid held w/o bready", 32'(bvalid), 32'd1);
    end
    checkOutput("no AW accept during B", 32'(awready), 32'd0);
    checkOutput("stalled bresp", 32'(bresp), 32'(RESP_OKAY));
    bready = 1;
    @(negedge clk);
    bready = 0;
    checkOutput("bvalid clears", 32'(bvalid), 32'd0);
    axiRead(12'h014, rdVal, respVal);
    checkOutput("rd port word strb 0x3", rdVal, 32'h00001234);
    axiWrite(12'h014, 32'hABCDEF00, 4'h4, respVal);
    axiRead(12'h014, rdVal, respVal);
    checkOutput("rd port word strb 0x4", rdVal, 32'h00CD1234);

    // Event counters
    for (int i = 0; i < 10; i++) begin
      pktSeen = 1;
      @(negedge clk);
      pktSeen = 0;
      if (i == 0) checkOutput("first pulse visible next cycle", cnts.pkt_seen, 32'd1);
      @(negedge clk);
    end
    checkOutput("pkt_seen live", cnts.pkt_seen, 32'd10);
    axiRead(12'h038, rdVal, respVal);
    checkOutput("rd pkt_seen", rdVal, 32'd10);
    rule0Hit = 1; pktDrop = 1; pktSeen = 1;
    @(negedge clk);
    @(negedge clk);
    rule0Hit = 0; pktDrop = 0; pktSeen = 0;
    @(negedge clk);
    checkOutput("rule0_hit combo", cnts.rule0_hit, 32'd2);
    checkOutput("pkt_drop combo", cnts.pkt_drop, 32'd2);
    checkOutput("pkt_seen combo", cnts.pkt_seen, 32'd12);
    axiRead(12'h030, rdVal, respVal);
    checkOutput("rd rule0_hit", rdVal, 32'd2);
    // Clear coincident with a pulse
    awaddr = 12'h038; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; pktSeen = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; pktSeen = 0;
    checkOutput("clear plus pulse", cnts.pkt_seen, 32'd1);
    checkOutput("clear bvalid", 32'(bvalid), 32'd1);
    bready = 1;
    @(negedge clk);
    bready = 0;
    checkOutput("other counter untouched", cnts.rule0_hit, 32'd2);
    axiWrite(12'h040, 32'h2, 4'hF, respVal);
    checkOutput("clr_all rule0", cnts.rule0_hit, 32'd0);
    checkOutput("clr_all drop", cnts.pkt_drop, 32'd0);
    checkOutput("clr_all seen", cnts.pkt_seen, 32'd0);
    checkOutput("clr_all no commit", activeRules[0].ipv4_addr, 32'hC0A80001);

    // Wrap
    force dut.uCntRule1Hit.count_q = 32'hFFFFFFFF;
    #1;
    release dut.uCntRule1Hit.count_q;
    checkOutput("rule1_hit preloaded", cnts.rule1_hit, 32'hFFFFFFFF);
    rule1Hit = 1;
    @(negedge clk);
    rule1Hit = 0;
    checkOutput("rule1_hit wraps", cnts.rule1_hit, 32'd0);

    // Unmapped accesses
    pktSeen = 1;
    repeat (3) @(negedge clk);
    pktSeen = 0;
    axiRead(12'h080, rdVal, respVal);
    checkOutput("rd 0x080 data", rdVal, 32'd0);
    checkOutput("rd 0x080 resp", 32'(respVal), 32'(RESP_SLVERR));
    axiRead(12'h044, rdVal, respVal);
    checkOutput("rd 0x044 resp", 32'(respVal), 32'(RESP_SLVERR));
    axiWrite(12'h080, 32'hDEADBEEF, 4'hF, respVal);
    checkOutput("wr 0x080 resp", 32'(respVal), 32'(RESP_SLVERR));
    axiWrite(12'h0B8, 32'h0, 4'hF, respVal);
    checkOutput("wr 0x0B8 resp", 32'(respVal), 32'(RESP_SLVERR));
    axiRead(12'h000, rdVal, respVal);
    checkOutput("shadow unchanged by unmapped", rdVal, 32'h11111111);
    checkOutput("counter unchanged by unmapped", cnts.pkt_seen, 32'd3);
    checkOutput("active unchanged by unmapped", activeRules[0].ipv4_addr, 32'hC0A80001);

    // Reset with B and R responses pending
    awaddr = 12'h004; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 12'h000; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    checkOutput("pending bvalid", 32'(bvalid), 32'd1);
    checkOutput("pending rvalid", 32'(rvalid), 32'd1);
    rstN = 0;
    #1;
    checkOutput("reset drops bvalid", 32'(bvalid), 32'd0);
    checkOutput("reset drops rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset clears counters", 32'(cnts != '0), 32'd0);
    checkOutput("reset clears active", 32'(activeRules != '0), 32'd0);
    @(negedge clk);
    rstN = 1;
    @(negedge clk);
    checkOutput("readies after reset", {29'd0, awready, wready, arready}, 32'h7);
    axiRead(12'h004, rdVal, respVal);
    checkOutput("shadow 0x004 after reset", rdVal, 32'd0);
    axiRead(12'h000, rdVal, respVal);
    checkOutput("shadow 0x000 after reset", rdVal, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
